// File: rtl/rr_req_arbiter.sv
// Round-robin arbiter: 8 requesters share one resource. The grant is held until the
// owner signals done or drops its request. Optional grant-hold watchdog is built when
// RR_ARB_WATCHDOG_EN is defined; otherwise timeout_o is tied low.
module rr_req_arbiter #(
  parameter int unsigned N    = 8,
  parameter int unsigned IDXW = 3
`ifdef RR_ARB_WATCHDOG_EN
  ,
  parameter int unsigned MAX_HOLD = 16
`endif
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            done_i,
  output logic [N-1:0]    gnt_o,
  output logic [IDXW-1:0] gnt_idx_o,
  output logic            gnt_vld_o,
  output logic            timeout_o
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic            pick_vld;
  logic [IDXW-1:0] pick_idx;
  logic [IDXW-1:0] cand;
  logic            release_req;
  logic            force_rel;

  // Rotating scan: walk from the farthest offset down so the nearest set bit at or after
  // ptr wins. Index arithmetic wraps naturally at IDXW bits.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      cand = ptr_q + IDXW'(k);
      if (req_i[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Owner finishes or withdraws; both at once are a single release.
  assign release_req = done_i | ~req_i[idx_q];

`ifdef RR_ARB_WATCHDOG_EN
  localparam int unsigned HoldW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

  logic [HoldW-1:0] hold_q, hold_d;
  logic             timeout_q, timeout_d;

  // A normal release on the limit cycle takes priority, so no forced release then.
  assign force_rel = (state_q == StGrant) && !release_req &&
                     (hold_q == HoldW'(MAX_HOLD - 1));

  // Hold counter runs only while a grant is kept; timeout pulses with the forced release.
  always_comb begin
    hold_d    = '0;
    timeout_d = force_rel;
    if ((state_q == StGrant) && !release_req && !force_rel) begin
      hold_d = hold_q + HoldW'(1);
    end
  end

  // Watchdog state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign force_rel = 1'b0;
  assign timeout_o = 1'b0;
`endif

  // Next-state: grant from IDLE, release (normal or forced) from GRANT with ptr advance.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_vld) begin
          state_d         = StGrant;
          idx_d           = pick_idx;
          gnt_d           = '0;
          gnt_d[pick_idx] = 1'b1;
        end
      end
      StGrant: begin
        if (release_req || force_rel) begin
          state_d = StIdle;
          idx_d   = '0;
          gnt_d   = '0;
          ptr_d   = idx_q + IDXW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbiter state register; reset drops any grant at once.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;
  assign gnt_vld_o = (state_q == StGrant);

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Self-checking bench for rr_req_arbiter: directed scenarios followed by random traffic,
// compared against an integer-level round-robin model.
module tb_rr_req_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  // Model: owner index (-1 = none), pointer, cycles held, expected timeout pulse.
  int m_owner = -1;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_to = 1'b0;

`ifdef RR_ARB_WATCHDOG_EN
  localparam int MaxHold = 16;
`endif

  always #5 clk = ~clk;

  rr_req_arbiter dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .req_i    (req),
    .done_i   (done),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_vld_o(gnt_vld),
    .timeout_o(timeout)
  );

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] eg;
    eg = 8'h00;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    check1({tag, ".gnt"}, 32'(gnt), 32'(eg));
    check1({tag, ".idx"}, 32'(gnt_idx), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check1({tag, ".vld"}, 32'(gnt_vld), (m_owner < 0) ? 32'd0 : 32'd1);
    check1({tag, ".timeout"}, 32'(timeout), 32'(m_to));
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  // One clock edge of the arbiter rules, applied to the current req/done.
  function automatic void model_step();
    int i;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int d = 0; d < 8; d++) begin
        i = (m_ptr + d) % 8;
        if (req[i]) begin
          m_owner = i;
          m_hold  = 0;
          break;
        end
      end
    end else if (done || !req[m_owner]) begin
      m_ptr   = (m_owner + 1) % 8;
      m_owner = -1;
    end else begin
`ifdef RR_ARB_WATCHDOG_EN
      if (m_hold == MaxHold - 1) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
`endif
    end
  endfunction

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset and idle
    req  = 8'h00;
    done = 1'b0;
    do_reset();
    repeat (5) tick("t1_idle");

    // Two requesters, ptr = 0: grant 2, then 4 after done
    req = 8'h14;
    tick("t2_grant2");
    check1("t2_idx2", 32'(gnt_idx), 32'd2);
    done = 1'b1;
    tick("t2_rel");
    done = 1'b0;
    tick("t2_grant4");
    check1("t2_gnt4", 32'(gnt), 32'h10);
    req = 8'h00;
    tick("t2_drop");

    // All requesting: indices 0..7,0 with an idle cycle between grants
    do_reset();
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick("t3_grant");
      check1("t3_seq", 32'(gnt_idx), 32'(g % 8));
      done = 1'b1;
      tick("t3_bubble");
      check1("t3_bubble_vld", 32'(gnt_vld), 32'd0);
      done = 1'b0;
    end

    // Owner 3 drops req together with done: one release, then req[1] served
    do_reset();
    req = 8'h08;
    tick("t4_grant3");
    req  = 8'h02;
    done = 1'b1;
    tick("t4_rel");
    done = 1'b0;
    tick("t4_grant1");
    check1("t4_gnt1", 32'(gnt), 32'h02);

    // Async reset mid-grant of owner 5
    req = 8'h20;
    tick("t5_rel1");
    tick("t5_grant5");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check1("t5_async_gnt", 32'(gnt), 32'h00);
    check_outputs("t5_async");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 8'h21;
    tick("t5_after");
    check1("t5_idx0", 32'(gnt_idx), 32'd0);

    // Long hold by requester 6
    req = 8'h00;
    tick("t6_rel");
    req = 8'h40;
    tick("t6_grant6");
`ifdef RR_ARB_WATCHDOG_EN
    repeat (15) tick("t6_hold");
    check1("t6_still_held", 32'(gnt_vld), 32'd1);
    req = 8'hC0;
    tick("t6_timeout");
    check1("t6_timeout_pulse", 32'(timeout), 32'd1);
    check1("t6_dropped", 32'(gnt_vld), 32'd0);
    tick("t6_next");
    check1("t6_ptr7", 32'(gnt_idx), 32'd7);
    check1("t6_pulse_end", 32'(timeout), 32'd0);
`else
    repeat (100) tick("t6_hold");
    check1("t6_still_held", 32'(gnt), 32'h40);
    req  = 8'hC0;
    done = 1'b1;
    tick("t6_rel2");
    done = 1'b0;
    tick("t6_next");
    check1("t6_ptr7", 32'(gnt_idx), 32'd7);
`endif

    // Random traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      req  = 8'($urandom);
      done = ($urandom_range(3) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
